set_job_arbiter: RTL and testbench

//  Shares one SET point-counting engine between NREQ requesters. Accepts jobs
//  (central/radius/mode), picks among them by round-robin and sequences the

---
 rtl/set_pkg.sv | 22 ++
 rtl/set_job_arbiter_if.sv | 48 ++++
 rtl/set_rr_pick.sv | 36 +++
 rtl/set_job_arbiter.sv | 163 ++++++++++++++++
 tb/tb_set_job_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/set_pkg.sv
// set_pkg: shared types and field widths for the SET job arbiter.
//   state_t        arbiter FSM states
//   CENT_W/RAD_W   packed centre / radius field widths of one job
//   MODE_W/CAND_W  mode and result widths
//   ENGINE_JOB_CYC nominal engine job length, used to size watchdog margins
package set_pkg;

    localparam int CENT_W         = 24;
    localparam int RAD_W          = 12;
    localparam int MODE_W         = 2;
    localparam int CAND_W         = 8;
    localparam int ENGINE_JOB_CYC = 768;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_VALID,
        RESPOND
    } state_t;

endpackage

// File: rtl/set_job_arbiter_if.sv
// set_job_arbiter_if: requester and engine handshake bundle of the arbiter.
//   req_valid/req_central/req_radius/req_mode  jobs from NREQ requesters
//   req_ready                                  one-hot accept pulse
//   rsp_valid/rsp_candidate/rsp_err            one-hot result pulse to owner
//   eng_en/eng_central/eng_radius/eng_mode     job towards the shared engine
//   eng_busy/eng_valid/eng_candidate           engine status and result
// Modports: slave = arbiter side, master = requesters + engine side.
interface set_job_arbiter_if
    import set_pkg::*;
#(
    parameter int NREQ = 4
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*CENT_W-1:0] req_central;
    logic [NREQ*RAD_W-1:0]  req_radius;
    logic [NREQ*MODE_W-1:0] req_mode;
    logic [NREQ-1:0]        req_ready;

    logic [NREQ-1:0]        rsp_valid;
    logic [CAND_W-1:0]      rsp_candidate;
    logic                   rsp_err;

    logic                   eng_en;
    logic [CENT_W-1:0]      eng_central;
    logic [RAD_W-1:0]       eng_radius;
    logic [MODE_W-1:0]      eng_mode;
    logic                   eng_busy;
    logic                   eng_valid;
    logic [CAND_W-1:0]      eng_candidate;

    modport slave (
        input  req_valid, req_central, req_radius, req_mode,
        output req_ready,
        output rsp_valid, rsp_candidate, rsp_err,
        output eng_en, eng_central, eng_radius, eng_mode,
        input  eng_busy, eng_valid, eng_candidate
    );

    modport master (
        output req_valid, req_central, req_radius, req_mode,
        input  req_ready,
        input  rsp_valid, rsp_candidate, rsp_err,
        input  eng_en, eng_central, eng_radius, eng_mode,
        output eng_busy, eng_valid, eng_candidate
    );

endinterface

// File: rtl/set_rr_pick.sv
// set_rr_pick: combinational round-robin pick.
//   req       pending request vector
//   ptr       highest-priority index this round
//   grant     one-hot winner (zero when no request)
//   grant_idx binary index of the winner
//   any       at least one request pending
// The search starts at ptr and wraps from NREQ-1 back to 0.
module set_rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any
);

    int slot;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        slot      = 0;
        for (int i = 0; i < NREQ; i++) begin
            slot = (int'(ptr) + i) % NREQ;
            if (!any && req[slot]) begin
                any         = 1'b1;
                grant[slot] = 1'b1;
                grant_idx   = PTR_W'(slot);
            end
        end
    end

endmodule

// File: rtl/set_job_arbiter.sv
// set_job_arbiter: shares one SET point-counting engine between NREQ
// requesters with round-robin selection and a watchdog.
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  set_job_arbiter_if.slave: requester jobs in, accept/result pulses
//        out, engine job out, engine busy/valid/candidate in
//
// state      | meaning
// IDLE       | waiting for a request (or for busy=0 after an abort)
// ISSUE      | req_ready and eng_en high for this one cycle
// WAIT_BUSY  | waiting for the engine to raise busy
// WAIT_VALID | engine running, watchdog counting
// RESPOND    | rsp_valid to the owner for this one cycle
module set_job_arbiter
    import set_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 2047
) (
    input logic              clk,
    input logic              rst,
    set_job_arbiter_if.slave bus
);

    localparam int                PTR_W    = $clog2(NREQ);
    localparam int                WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NREQ - 1);

    state_t              state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [NREQ-1:0]     owner_oh;
    logic [WD_W-1:0]     wdog;
    logic                err_hold;

    logic [NREQ-1:0]     req_ready_q;
    logic [NREQ-1:0]     rsp_valid_q;
    logic [CAND_W-1:0]   rsp_candidate_q;
    logic                rsp_err_q;
    logic                eng_en_q;
    logic [CENT_W-1:0]   eng_central_q;
    logic [RAD_W-1:0]    eng_radius_q;
    logic [MODE_W-1:0]   eng_mode_q;

    logic [NREQ-1:0]     pick_grant;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_any;
    logic                grant_ok;
    logic                wd_hit;
    logic [WD_W-1:0]     wd_next;

    set_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // After an abort the engine may still be running; never start it again
    // until it has dropped busy.
    assign grant_ok = pick_any && !(err_hold && bus.eng_busy);
    assign wd_hit   = (wdog == WD_MAX);
    assign wd_next  = wd_hit ? wdog : wdog + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            owner_oh        <= '0;
            wdog            <= '0;
            err_hold        <= 1'b0;
            req_ready_q     <= '0;
            rsp_valid_q     <= '0;
            rsp_candidate_q <= '0;
            rsp_err_q       <= 1'b0;
            eng_en_q        <= 1'b0;
            eng_central_q   <= '0;
            eng_radius_q    <= '0;
            eng_mode_q      <= '0;
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            eng_en_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (err_hold && !bus.eng_busy) begin
                        err_hold <= 1'b0;
                    end
                    if (grant_ok) begin
                        req_ready_q   <= pick_grant;
                        eng_en_q      <= 1'b1;
                        owner_oh      <= pick_grant;
                        eng_central_q <= bus.req_central[CENT_W*pick_idx +: CENT_W];
                        eng_radius_q  <= bus.req_radius[RAD_W*pick_idx +: RAD_W];
                        eng_mode_q    <= bus.req_mode[MODE_W*pick_idx +: MODE_W];
                        rr_ptr        <= (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
                        wdog          <= '0;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog  <= wd_next;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    wdog <= wd_next;
                    if (bus.eng_valid) begin
                        rsp_valid_q     <= owner_oh;
                        rsp_candidate_q <= bus.eng_candidate;
                        rsp_err_q       <= 1'b0;
                        state           <= RESPOND;
                    end else if (bus.eng_busy) begin
                        state <= WAIT_VALID;
                    end else if (wd_hit) begin
                        // also covers an engine that never raises busy
                        rsp_valid_q     <= owner_oh;
                        rsp_candidate_q <= '0;
                        rsp_err_q       <= 1'b1;
                        state           <= RESPOND;
                    end
                end
                WAIT_VALID: begin
                    wdog <= wd_next;
                    // valid takes priority over a watchdog hit on the same cycle
                    if (bus.eng_valid) begin
                        rsp_valid_q     <= owner_oh;
                        rsp_candidate_q <= bus.eng_candidate;
                        rsp_err_q       <= 1'b0;
                        state           <= RESPOND;
                    end else if (wd_hit) begin
                        rsp_valid_q     <= owner_oh;
                        rsp_candidate_q <= '0;
                        rsp_err_q       <= 1'b1;
                        state           <= RESPOND;
                    end
                end
                RESPOND: begin
                    rsp_candidate_q <= '0;
                    rsp_err_q       <= 1'b0;
                    err_hold        <= rsp_err_q;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_candidate = rsp_candidate_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.eng_en        = eng_en_q;
    assign bus.eng_central   = eng_central_q;
    assign bus.eng_radius    = eng_radius_q;
    assign bus.eng_mode      = eng_mode_q;

endmodule

// File: tb/tb_set_job_arbiter.sv
// tb_set_job_arbiter: scoreboard bench for set_job_arbiter with a
// behavioural engine and NREQ=4 requesters.
module tb_set_job_arbiter;
    import set_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 2047;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    set_job_arbiter_if #(.NREQ(NREQ)) bus();

    set_job_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          idx;
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
    } grant_t;

    typedef struct {
        int          idx;
        logic [7:0]  cand;
        logic        err;
        int          delay;
    } rsp_t;

    grant_t gq[$];
    rsp_t   rq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] CEN [NREQ] = '{24'h10A0B1, 24'h7F3C22, 24'h226488, 24'hFFEE05};
    logic [11:0] RAD [NREQ] = '{12'h0F1, 12'hABC, 12'h333, 12'h012};
    logic [1:0]  MOD [NREQ] = '{2'd1, 2'd2, 2'd0, 2'd3};

    int arm_cnt  [NREQ] = '{default: 0};
    int arm_done [NREQ] = '{default: 0};

    bit eng_hang    = 1'b0;
    bit eng_release = 1'b0;
    int eng_lat     = 5;
    int en_cycle    = 0;
    int en_count    = 0;

    function automatic logic [7:0] model_cand(input logic [23:0] c, input logic [11:0] r,
                                              input logic [1:0] m);
        return c[7:0] ^ r[7:0] ^ {6'b0, m} ^ 8'h9B;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_job(input int i);
        gq.push_back('{i, CEN[i], RAD[i], MOD[i]});
        rq.push_back('{i, model_cand(CEN[i], RAD[i], MOD[i]), 1'b0, eng_lat + 2});
    endtask

    task automatic wait_drain(input string nm, input int maxc);
        int t;
        t = 0;
        while ((gq.size() != 0 || rq.size() != 0) && t < maxc) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_drain"}, gq.size() + rq.size(), 0);
    endtask

    task automatic wait_rsp_bit(input int i, input int maxc);
        int t;
        t = 0;
        while (!bus.rsp_valid[i] && t < maxc) begin
            @(negedge clk);
            t++;
        end
        check("wait_rsp", (t >= maxc) ? 1 : 0, 0);
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_req_ready"}, bus.req_ready, 0);
        check({nm, "_rsp_valid"}, bus.rsp_valid, 0);
        check({nm, "_rsp_cand"}, bus.rsp_candidate, 0);
        check({nm, "_rsp_err"}, bus.rsp_err, 0);
        check({nm, "_eng_en"}, bus.eng_en, 0);
        check({nm, "_eng_central"}, bus.eng_central, 0);
        check({nm, "_eng_radius"}, bus.eng_radius, 0);
        check({nm, "_eng_mode"}, bus.eng_mode, 0);
    endtask

    // requesters: hold valid until ready, then scramble own data
    initial begin
        bus.req_valid   = '0;
        bus.req_central = '0;
        bus.req_radius  = '0;
        bus.req_mode    = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_ready[i]) begin
                    bus.req_valid[i]         = 1'b0;
                    bus.req_central[24*i+:24] = ~CEN[i];
                    bus.req_radius[12*i+:12]  = ~RAD[i];
                    bus.req_mode[2*i+:2]      = ~MOD[i];
                end
                if (arm_done[i] != arm_cnt[i]) begin
                    arm_done[i]++;
                    bus.req_central[24*i+:24] = CEN[i];
                    bus.req_radius[12*i+:12]  = RAD[i];
                    bus.req_mode[2*i+:2]      = MOD[i];
                    bus.req_valid[i]         = 1'b1;
                end
            end
        end
    end

    // behavioural engine with stability tracking
    initial begin : engine
        logic [23:0] cap_c;
        logic [11:0] cap_r;
        logic [1:0]  cap_m;
        bit          unstable;
        bit          ab;
        int          w;
        bus.eng_busy      = 1'b0;
        bus.eng_valid     = 1'b0;
        bus.eng_candidate = '0;
        forever begin
            @(negedge clk);
            if (bus.eng_en) begin
                en_cycle = cyc;
                en_count++;
                cap_c    = bus.eng_central;
                cap_r    = bus.eng_radius;
                cap_m    = bus.eng_mode;
                unstable = 1'b0;
                @(posedge clk);
                #1;
                if (!rst) begin
                    bus.eng_busy = 1'b1;
                    if (eng_hang) begin
                        w = 0;
                        while (!eng_release && !rst && w < 10000) begin
                            @(posedge clk);
                            #1;
                            w++;
                            if (bus.eng_central !== cap_c || bus.eng_radius !== cap_r ||
                                bus.eng_mode !== cap_m) unstable = 1'b1;
                        end
                        check("stable_hang", unstable, 0);
                        bus.eng_busy = 1'b0;
                    end else begin
                        ab = 1'b0;
                        for (int k = 0; k < eng_lat; k++) begin
                            @(posedge clk);
                            #1;
                            if (rst) begin
                                ab = 1'b1;
                                break;
                            end
                            if (bus.eng_central !== cap_c || bus.eng_radius !== cap_r ||
                                bus.eng_mode !== cap_m) unstable = 1'b1;
                        end
                        if (ab) begin
                            bus.eng_busy = 1'b0;
                        end else begin
                            check("stable_job", unstable, 0);
                            bus.eng_valid     = 1'b1;
                            bus.eng_candidate = model_cand(cap_c, cap_r, cap_m);
                            @(posedge clk);
                            #1;
                            bus.eng_valid = 1'b0;
                            bus.eng_busy  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // en must never coincide with busy
    initial begin
        forever begin
            @(negedge clk);
            if (bus.eng_en) check("en_while_busy", bus.eng_busy, 0);
        end
    end

    // grant monitor
    initial begin : gmon
        grant_t g;
        forever begin
            @(negedge clk);
            if (|bus.req_ready) begin
                if (gq.size() == 0) begin
                    check("unexpected_grant", bus.req_ready, 0);
                end else begin
                    g = gq.pop_front();
                    check("grant_onehot", bus.req_ready, 32'(1) << g.idx);
                    check("grant_en", bus.eng_en, 1);
                    check("grant_central", bus.eng_central, g.c);
                    check("grant_radius", bus.eng_radius, g.r);
                    check("grant_mode", bus.eng_mode, g.m);
                end
            end
        end
    end

    // response monitor
    initial begin : rmon
        rsp_t r;
        forever begin
            @(negedge clk);
            if (|bus.rsp_valid) begin
                if (rq.size() == 0) begin
                    check("unexpected_rsp", bus.rsp_valid, 0);
                end else begin
                    r = rq.pop_front();
                    check("rsp_onehot", bus.rsp_valid, 32'(1) << r.idx);
                    check("rsp_cand", bus.rsp_candidate, r.cand);
                    check("rsp_err", bus.rsp_err, r.err);
                    check("rsp_delay", cyc - en_cycle, r.delay);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // single job on requester 2, engine answers 32
        gq.push_back('{2, CEN[2], RAD[2], MOD[2]});
        rq.push_back('{2, 8'd32, 1'b0, 7});
        arm_cnt[2]++;
        wait_drain("single", 200);
        check("single_en_count", en_count, 1);

        // rr_ptr is now 3: 1001 -> 3, 0; re-armed 3 waits behind 0
        expect_job(3);
        expect_job(0);
        expect_job(3);
        arm_cnt[3]++;
        arm_cnt[0]++;
        wait_rsp_bit(3, 200);
        arm_cnt[3]++;
        wait_drain("wrap", 400);

        // rr_ptr is now 0: 1111 -> 0,1,2,3 then re-armed 0
        for (int i = 0; i < NREQ; i++) expect_job(i);
        expect_job(0);
        for (int i = 0; i < NREQ; i++) arm_cnt[i]++;
        wait_rsp_bit(0, 200);
        arm_cnt[0]++;
        wait_drain("contention", 600);

        // watchdog: rr_ptr=1, engine stays busy and never answers
        eng_hang = 1'b1;
        gq.push_back('{1, CEN[1], RAD[1], MOD[1]});
        rq.push_back('{1, 8'd0, 1'b1, TIMEOUT + 1});
        arm_cnt[1]++;
        wait_drain("watchdog", TIMEOUT + 100);
        eng_hang = 1'b0;
        expect_job(2);
        arm_cnt[2]++;
        repeat (20) @(negedge clk);
        check("no_grant_while_busy", gq.size(), 1);
        eng_release = 1'b1;
        wait_drain("after_wd", 200);
        eng_release = 1'b0;

        // reset in the middle of a long job, rr_ptr=3 before reset
        eng_lat = ENGINE_JOB_CYC;
        gq.push_back('{2, CEN[2], RAD[2], MOD[2]});
        arm_cnt[2]++;
        wait_drain("long_grant", 200);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("mid_reset");
        rst = 1'b0;
        eng_lat = 5;
        repeat (3) @(negedge clk);
        expect_job(1);
        expect_job(3);
        arm_cnt[1]++;
        arm_cnt[3]++;
        wait_drain("post_reset", 300);
        check("total_en_count", en_count, 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
